// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART/ALU sequencer.
// Contents: state encoding width, FSM state type, default payload/opcode widths.
package uart_alu_pkg;

  localparam int unsigned NB_STATE    = 3;
  localparam int unsigned NB_DATA_DEF = 8;
  localparam int unsigned NB_OP_DEF   = 6;

  typedef enum logic [NB_STATE-1:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

endpackage

// File: rtl/uart_alu_ctrl_edge_pulse.sv
// Rising-edge pulse generator: turns a level that may stay high for many
// clocks into a single one-clock event.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous, active-high reset
//   level  in  input level
//   pulse  out high for the first clock the level is seen high
module edge_pulse (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic level_d;

  always_ff @(posedge clock) begin
    if (reset) level_d <= 1'b0;
    else       level_d <= level;
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/uart_alu_ctrl.sv
// Sequencer between UART RX, an external combinational ALU and UART TX.
// Collects operand A, operand B and opcode frames, presents them to the ALU,
// captures the result and hands it to the transmitter.
// Optional feature macro: UART_ALU_PARITY_CHK_EN (even parity over the whole
// RX frame; bad frames are rejected and pulse o_parity_err).
// Ports:
//   i_clock, i_reset      clock, synchronous active-high reset
//   i_tick                baud tick strobe (drives the inter-frame timeout)
//   i_rx_data/i_rx_done   received frame {payload, parity} and ready level
//   i_tx_done             transmitter frame-sent level
//   i_alu_result          combinational ALU result
//   o_alu_a/b/op          ALU operand and opcode registers
//   o_tx_data/o_tx_start  byte to transmit and one-clock start pulse
//   o_busy                high outside ST_IDLE
//   o_timeout             one-clock pulse on an aborted partial command
//   o_parity_err          one-clock pulse on a rejected frame
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_DATA       = NB_DATA_DEF,
  parameter int unsigned NB_OP         = NB_OP_DEF,
  parameter int unsigned TIMEOUT_TICKS = 2048,
  parameter int unsigned NB_TIMEOUT    = 12
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic [NB_DATA:0]   i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_parity_err
);

  state_t state, state_next;

  logic rx_evt, tx_evt;
  logic load_a, load_b, load_op, load_tx;
  logic frame_ok;
  logic waiting;
  logic cnt_full;
  logic [NB_TIMEOUT-1:0] cnt;
  logic [NB_DATA-1:0]    payload;

  edge_pulse u_rx_edge (
    .clock (i_clock),
    .reset (i_reset),
    .level (i_rx_done),
    .pulse (rx_evt)
  );

  edge_pulse u_tx_edge (
    .clock (i_clock),
    .reset (i_reset),
    .level (i_tx_done),
    .pulse (tx_evt)
  );

  assign payload = i_rx_data[NB_DATA:1];

`ifdef UART_ALU_PARITY_CHK_EN
  assign frame_ok = ~^i_rx_data;
`else
  logic unused_parity;
  assign unused_parity = i_rx_data[0];
  assign frame_ok      = 1'b1;
`endif

  assign waiting  = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
  assign cnt_full = (cnt == NB_TIMEOUT'(TIMEOUT_TICKS));
  assign o_busy   = (state != ST_IDLE);

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_next;
  end

  // rx_evt has priority over the timeout, so a frame arriving on the final
  // tick (or while the counter sits saturated) is still accepted.
  always_comb begin
    state_next   = state;
    load_a       = 1'b0;
    load_b       = 1'b0;
    load_op      = 1'b0;
    load_tx      = 1'b0;
    o_tx_start   = 1'b0;
    o_timeout    = 1'b0;
    o_parity_err = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_evt) begin
          if (frame_ok) begin
            load_a     = 1'b1;
            state_next = ST_WAIT_B;
          end else begin
            o_parity_err = 1'b1;
          end
        end
      end
      ST_WAIT_B: begin
        if (rx_evt) begin
          if (frame_ok) begin
            load_b     = 1'b1;
            state_next = ST_WAIT_OP;
          end else begin
            o_parity_err = 1'b1;
            state_next   = ST_IDLE;
          end
        end else if (cnt_full) begin
          o_timeout  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WAIT_OP: begin
        if (rx_evt) begin
          if (frame_ok) begin
            load_op    = 1'b1;
            state_next = ST_EXEC;
          end else begin
            o_parity_err = 1'b1;
            state_next   = ST_IDLE;
          end
        end else if (cnt_full) begin
          o_timeout  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_EXEC: begin
        load_tx    = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        o_tx_start = 1'b1;
        state_next = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (tx_evt) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
    end else begin
      if (load_a)  o_alu_a   <= payload;
      if (load_b)  o_alu_b   <= payload;
      if (load_op) o_alu_op  <= payload[NB_OP-1:0];
      if (load_tx) o_tx_data <= i_alu_result;
    end
  end

  // Inter-frame tick counter; saturates at TIMEOUT_TICKS.
  always_ff @(posedge i_clock) begin
    if (i_reset || rx_evt || (state == ST_IDLE)) cnt <= '0;
    else if (i_tick && waiting && !cnt_full)     cnt <= cnt + 1'b1;
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
module tb_uart_alu_ctrl;

  localparam int unsigned TO_TICKS = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [8:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] alu_result;
  logic [7:0] alu_a, alu_b, tx_data;
  logic [5:0] alu_op;
  logic       tx_start, busy, timeout, parity_err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned evt_cyc = 0;
  int unsigned n_starts = 0;
  int unsigned n_timeouts = 0;
  int unsigned n_perr = 0;
  logic [7:0] sb[$];

  uart_alu_ctrl #(
    .NB_DATA       (8),
    .NB_OP         (6),
    .TIMEOUT_TICKS (TO_TICKS),
    .NB_TIMEOUT    (12)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_tick       (tick),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_result),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_timeout    (timeout),
    .o_parity_err (parity_err)
  );

  // External ALU model: addition.
  assign alu_result = alu_a + alu_b;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // One-clock-wide tick every second clock.
  initial forever begin
    @(posedge clk);
    #1 tick = ~tick;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: scoreboard compare on every tx start, count event pulses.
  initial forever begin
    @(negedge clk);
    if (tx_start) begin
      n_starts = n_starts + 1;
      if (sb.size() == 0) check("unexpected_start", 32'd1, 32'd0);
      else check("tx_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      check("start_latency", cyc - evt_cyc, 32'd2);
    end
    if (timeout)    n_timeouts = n_timeouts + 1;
    if (parity_err) n_perr     = n_perr + 1;
  end

  task automatic send_frame(input logic [7:0] p, input int hold, input bit bad_par);
    @(posedge clk);
    #1;
    rx_data = {p, (^p) ^ bad_par};
    rx_done = 1'b1;
    evt_cyc = cyc;
    repeat (hold) @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic do_tx_done();
    @(posedge clk);
    #1 tx_done = 1'b1;
    repeat (5) @(posedge clk);
    #1 tx_done = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_starts(input int unsigned target, input int budget);
    for (int i = 0; i < budget && n_starts < target; i++) @(posedge clk);
    @(negedge clk);
    check("start_count", n_starts, target);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_a",       {24'd0, alu_a},   32'd0);
    check("rst_b",       {24'd0, alu_b},   32'd0);
    check("rst_op",      {26'd0, alu_op},  32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_start",   {31'd0, tx_start}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
  endtask

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int hold);
    sb.push_back(a + b);
    send_frame(a, hold, 1'b0);
    send_frame(b, hold, 1'b0);
    send_frame(op, hold, 1'b0);
  endtask

  initial begin
    int unsigned s0, t0, p0;

    do_reset();

    // 1: basic command
    run_cmd(8'h05, 8'h03, 8'h20, 1);
    check("t1_a",  {24'd0, alu_a},  32'h05);
    check("t1_b",  {24'd0, alu_b},  32'h03);
    check("t1_op", {26'd0, alu_op}, 32'h20);
    wait_starts(1, 20);
    check("t1_busy_wait_tx", {31'd0, busy}, 32'd1);
    do_tx_done();
    @(negedge clk);
    check("t1_busy_done", {31'd0, busy}, 32'd0);

    // 2: long rx_done levels, opcode truncated to low 6 bits
    run_cmd(8'h11, 8'h22, 8'hE5, 16);
    check("t2_op", {26'd0, alu_op}, 32'h25);
    wait_starts(2, 20);
    do_tx_done();
    @(negedge clk);
    check("t2_busy_done", {31'd0, busy}, 32'd0);

    // 3: inter-frame timeout
    t0 = n_timeouts;
    send_frame(8'h05, 1, 1'b0);
    for (int i = 0; i < 6000 && n_timeouts == t0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("t3_timeouts", n_timeouts - t0, 32'd1);
    check("t3_busy",     {31'd0, busy},  32'd0);
    check("t3_a_kept",   {24'd0, alu_a}, 32'h05);
    run_cmd(8'h01, 8'h02, 8'h20, 1);
    wait_starts(3, 20);
    do_tx_done();

    // 4: frame during ST_WAIT_TX is dropped
    run_cmd(8'h03, 8'h04, 8'h20, 1);
    wait_starts(4, 20);
    send_frame(8'h55, 1, 1'b0);
    @(negedge clk);
    check("t4_busy",   {31'd0, busy},  32'd1);
    check("t4_a_kept", {24'd0, alu_a}, 32'h03);
    do_tx_done();
    @(negedge clk);
    check("t4_idle", {31'd0, busy}, 32'd0);
    run_cmd(8'h06, 8'h04, 8'h20, 1);
    check("t4_fresh_a", {24'd0, alu_a}, 32'h06);
    wait_starts(5, 20);
    do_tx_done();

    // 5: reset mid-command
    s0 = n_starts;
    send_frame(8'h09, 1, 1'b0);
    send_frame(8'h0A, 1, 1'b0);
    do_reset();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t5_no_start", n_starts, s0);

    // 6: bad parity on the second frame
    p0 = n_perr;
`ifdef UART_ALU_PARITY_CHK_EN
    send_frame(8'h10, 1, 1'b0);
    send_frame(8'h0C, 1, 1'b1);
    @(negedge clk);
    check("t6_perr",   n_perr - p0,    32'd1);
    check("t6_b_kept", {24'd0, alu_b}, 32'h00);
    check("t6_busy",   {31'd0, busy},  32'd0);
`else
    sb.push_back(8'h10 + 8'h0C);
    send_frame(8'h10, 1, 1'b0);
    send_frame(8'h0C, 1, 1'b1);
    check("t6_b", {24'd0, alu_b}, 32'h0C);
    send_frame(8'h20, 1, 1'b0);
    wait_starts(s0 + 1, 20);
    do_tx_done();
    check("t6_perr_none", n_perr - p0, 32'd0);
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
